// File: rtl/frame_writer.sv
// Double-buffered pixel framebuffer: commands edit a hidden back buffer,
// COMMIT copies it whole into the front buffer that drives the row scanner.
module frame_writer #(
  parameter  int unsigned ROWS = 8,
  parameter  int unsigned COLS = 16,
  localparam int unsigned XW   = $clog2(COLS),
  localparam int unsigned YW   = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [XW-1:0]        cmd_x,
  input  logic [YW-1:0]        cmd_y,
  input  logic                 cmd_val,
  output logic [ROWS*COLS-1:0] pixelReg,
  output logic                 commit_done
);

  localparam int unsigned NPIX = ROWS * COLS;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned RW   = (YW > 0) ? YW : 1;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_COMMIT = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [NPIX-1:0]   bb_q, bb_d;
  logic [NPIX-1:0]   pix_q, pix_d;
  logic              commit_done_q, commit_done_d;

  logic [AW-1:0]     addr_c;
  logic              in_range_c;

  // Linear pixel address and a guard for out-of-matrix coordinates
  always_comb begin
    addr_c     = AW'(COLS * 32'(cmd_y) + 32'(cmd_x));
    in_range_c = (32'(cmd_x) < COLS) && (32'(cmd_y) < ROWS);
  end

  // Ready depends on state only so the source can hold a command while busy
  assign cmd_ready   = (state_q == ST_IDLE);
  assign pixelReg    = pix_q;
  assign commit_done = commit_done_q;

  // State, row counter and both buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      r_q           <= '0;
      bb_q          <= '0;
      pix_q         <= '0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      bb_q          <= bb_d;
      pix_q         <= pix_d;
      commit_done_q <= commit_done_d;
    end
  end

  // Command decode in IDLE; row-by-row wipe of the back buffer in CLEAR
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    bb_d          = bb_q;
    pix_d         = pix_q;
    commit_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_SET: begin
              if (in_range_c) bb_d[addr_c] = cmd_val;
            end
            OP_TOGGLE: begin
              if (in_range_c) bb_d[addr_c] = ~bb_q[addr_c];
            end
            OP_CLEAR: begin
              r_d     = '0;
              state_d = ST_CLEAR;
            end
            OP_COMMIT: begin
              pix_d         = bb_q;
              commit_done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_CLEAR: begin
        bb_d[COLS*32'(r_q) +: COLS] = '0;
        if (r_q == RW'(ROWS - 1)) begin
          r_d     = '0;
          state_d = ST_IDLE;
        end else begin
          r_d = r_q + RW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
